// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// opcode/funct values, ALU commands and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_RWB    = 4'd7,
        S_EXECI  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_TRAP   = 4'd14
    } state_e;

    typedef enum logic [3:0] {
        IC_RTYPE,
        IC_JR,
        IC_LW,
        IC_SW,
        IC_IMM,
        IC_BR,
        IC_J,
        IC_JAL,
        IC_ILLEGAL
    } iclass_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_SLT = 3'd3
    } alu_cmd_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    function automatic logic is_mem_req_state(state_e s);
        return s inside {S_FETCH, S_MEMRD, S_MEMWR};
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class
// and the ALU command used by the execute and branch steps.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_e    iclass,
    output alu_cmd_e   alu_cmd
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        iclass  = IC_ILLEGAL;
        alu_cmd = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin iclass = IC_RTYPE; alu_cmd = ALU_ADD; end
                    FN_SUB: begin iclass = IC_RTYPE; alu_cmd = ALU_SUB; end
                    FN_SLT: begin iclass = IC_RTYPE; alu_cmd = ALU_SLT; end
                    FN_JR:  iclass = IC_JR;
                    default: ;
                endcase
            end
            OP_LW:   iclass = IC_LW;
            OP_SW:   iclass = IC_SW;
            OP_ADDI: begin iclass = IC_IMM; alu_cmd = ALU_ADD; end
            OP_XORI: begin iclass = IC_IMM; alu_cmd = ALU_XOR; end
            OP_BEQ,
            OP_BNE:  begin iclass = IC_BR; alu_cmd = ALU_SUB; end
            OP_J:    iclass = IC_J;
            OP_JAL:  iclass = IC_JAL;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle MIPS-subset CPU with memory req/ready wait timeout.
// Optional: define MC_PERF_COUNTERS_EN to add cycle_count / retire_count outputs.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pcsrc,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [2:0]  alu_cmd,
    output logic        reg_we,
    output logic [1:0]  regdst,
    output logic [1:0]  memtoreg,
    output logic        trap,
`ifdef MC_PERF_COUNTERS_EN
    output logic [31:0] cycle_count,
    output logic [31:0] retire_count,
`endif
    output logic [3:0]  state
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    iclass_e           iclass;
    alu_cmd_e          dec_alu_cmd;
    logic              ready;
    logic              req_state;
    logic              timeout_hit;
    logic              unused_instr_bits;

    mc_decode u_decode (
        .opcode  (instr[31:26]),
        .funct   (instr[5:0]),
        .iclass  (iclass),
        .alu_cmd (dec_alu_cmd)
    );

    assign unused_instr_bits = ^instr[25:6];

    // Ready is masked while reset is high so no write enable can fire during reset.
    assign ready       = mem_ready & ~reset;
    assign req_state   = is_mem_req_state(state_q);
    assign timeout_hit = (MEM_TIMEOUT != 0) && req_state && !ready && (wait_q == WAIT_LAST);

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            S_FETCH:  if (ready) state_d = S_DECODE;
            S_DECODE: begin
                case (iclass)
                    IC_RTYPE:    state_d = S_EXECR;
                    IC_JR:       state_d = S_JR;
                    IC_LW,
                    IC_SW:       state_d = S_MEMADR;
                    IC_IMM:      state_d = S_EXECI;
                    IC_BR:       state_d = S_BRANCH;
                    IC_J:        state_d = S_JUMP;
                    IC_JAL:      state_d = S_JAL;
                    default:     state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (iclass == IC_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (ready) state_d = S_MEMWB;
            S_MEMWR:  if (ready) state_d = S_FETCH;
            S_EXECR:  state_d = S_RWB;
            S_EXECI:  state_d = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                      state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
        if (timeout_hit) state_d = S_TRAP;
        // Any state change clears the wait counter; staying in a request state means a wait.
        if ((MEM_TIMEOUT != 0) && req_state && (state_d == state_q)) wait_d = wait_q + 1'b1;
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        iord     = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pcsrc    = PC_ALU;
        alusrca  = 1'b0;
        alusrcb  = SRCB_RT;
        alu_cmd  = ALU_ADD;
        reg_we   = 1'b0;
        regdst   = RD_RT;
        memtoreg = WB_ALUOUT;
        trap     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                ir_we   = ready;
                pc_we   = ready;
            end
            S_DECODE: alusrcb = SRCB_IMM_SH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_we   = 1'b1;
                memtoreg = WB_MEM;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_EXECR: begin
                alusrca = 1'b1;
                alu_cmd = dec_alu_cmd;
            end
            S_RWB: begin
                reg_we = 1'b1;
                regdst = RD_RD;
            end
            S_EXECI: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                alu_cmd = dec_alu_cmd;
            end
            S_IWB: reg_we = 1'b1;
            S_BRANCH: begin
                alusrca = 1'b1;
                alu_cmd = ALU_SUB;
                pcsrc   = PC_ALUOUT;
                pc_we   = (instr[31:26] == OP_BNE) ? !zero : zero;
            end
            S_JUMP: begin
                pcsrc = PC_JUMP;
                pc_we = 1'b1;
            end
            S_JAL: begin
                pcsrc    = PC_JUMP;
                pc_we    = 1'b1;
                reg_we   = 1'b1;
                regdst   = RD_RA;
                memtoreg = WB_PC;
            end
            S_JR: begin
                pcsrc = PC_RS;
                pc_we = 1'b1;
            end
            S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] retire_count_q, retire_count_d;

    always_comb begin
        cycle_count_d  = cycle_count_q + ((state_q != S_TRAP) ? 32'd1 : 32'd0);
        retire_count_d = retire_count_q
                       + (((state_d == S_FETCH) && (state_q != S_FETCH)) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_q  <= '0;
            retire_count_q <= '0;
        end else begin
            cycle_count_q  <= cycle_count_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign cycle_count  = cycle_count_q;
    assign retire_count = retire_count_q;
`endif

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multi-cycle MIPS-subset CPU. It sequences one shared ALU, one unified instruction/data memory, the register file and the PC register through fetch, decode, execute, memory and write-back steps. It issues every mux select and write enable for the datapath and performs a req/ready handshake with a variable-latency memory. It sits beside the datapath top level; the only datapath values it reads are the instruction register and the ALU zero flag.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: number of wait cycles on `mem_ready` before the block traps; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `instr` in 32: instruction register contents.
- `zero` in 1: ALU zero flag from the current cycle.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: memory write qualifier, valid only while `mem_req` is high.
- `iord` out 1: memory address select; 0 selects PC, 1 selects ALUOut.
- `ir_we` out 1: instruction register load.
- `pc_we` out 1: PC register load.
- `pcsrc` out 2: next-PC select; 0 selects ALU result, 1 selects ALUOut, 2 selects {PC[31:28], instr[25:0], 2'b00}, 3 selects rs data.
- `alusrca` out 1: ALU operand A; 0 selects PC, 1 selects rs data.
- `alusrcb` out 2: ALU operand B; 0 selects rt data, 1 selects constant 4, 2 selects sign-extended imm, 3 selects sign-extended imm<<2.
- `alu_cmd` out 3: ALU command; 0 ADD, 1 SUB, 2 XOR, 3 SLT.
- `reg_we` out 1: register file write enable.
- `regdst` out 2: write address select; 0 selects rt, 1 selects rd, 2 selects $31.
- `memtoreg` out 2: write data select; 0 selects ALUOut, 1 selects memory data, 2 selects PC (already PC+4).
- `trap` out 1: sticky error flag.
- `state` out 4: current state, for debug.

## Operation
- Opcode comes from `instr[31:26]` and funct from `instr[5:0]`.
- Legal instructions: R-type (0x00) with funct ADD 0x20, SUB 0x22, SLT 0x2A or JR 0x08; LW 0x23; SW 0x2B; ADDI 0x08; XORI 0x0E; BEQ 0x04; BNE 0x05; J 0x02; JAL 0x03.
- States and transitions:
  - FETCH: `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=1, ADD, `pcsrc`=0. On `mem_ready`, assert `ir_we` and `pc_we` and go to DECODE. Otherwise stay in FETCH.
  - DECODE: `alusrca`=0, `alusrcb`=3, ADD; this precomputes the branch target into ALUOut. Dispatch on opcode. Any illegal opcode or funct goes to TRAP.
  - MEMADR: `alusrca`=1, `alusrcb`=2, ADD. Go to MEMRD for LW or MEMWR for SW.
  - MEMRD: `mem_req`=1, `iord`=1. On `mem_ready` go to MEMWB.
  - MEMWB: `reg_we`=1, `regdst`=0, `memtoreg`=1. Go to FETCH.
  - MEMWR: `mem_req`=1, `mem_we`=1, `iord`=1. On `mem_ready` go to FETCH.
  - EXECR: `alusrca`=1, `alusrcb`=0, `alu_cmd` taken from funct. Go to RWB.
  - RWB: `reg_we`=1, `regdst`=1, `memtoreg`=0. Go to FETCH.
  - EXECI: `alusrca`=1, `alusrcb`=2, ADD for ADDI or XOR for XORI. Go to IWB.
  - IWB: `reg_we`=1, `regdst`=0, `memtoreg`=0. Go to FETCH.
  - BRANCH: `alusrca`=1, `alusrcb`=0, SUB, `pcsrc`=1. `pc_we` = `zero` for BEQ, or `!zero` for BNE. Go to FETCH.
  - JUMP: `pcsrc`=2, `pc_we`=1. Go to FETCH.
  - JAL: `pcsrc`=2, `pc_we`=1, `reg_we`=1, `regdst`=2, `memtoreg`=2. The register file sees the old PC this cycle. Go to FETCH.
  - JR: `pcsrc`=3, `pc_we`=1. Go to FETCH.
  - TRAP: all enables and `mem_req` are 0 and `trap`=1. The block leaves TRAP only on `reset`.
- Timeout: a wait counter counts cycles spent in any `mem_req` state without `mem_ready`. If it reaches `MEM_TIMEOUT`, the FSM goes to TRAP. The counter clears on every state change.
- Outputs are Moore-decoded from state. The only exceptions are `ir_we` and `pc_we`, which are also qualified by `mem_ready` and `zero` as listed above.

## Timing
- Reset state is FETCH and the wait counter is 0. While `reset` is high, `mem_req`=1 and every write enable is 0, because `pc_we`/`ir_we` depend on `mem_ready`. During reset, `mem_ready` is masked.
- Cycle counts with zero-wait memory (`mem_ready` high in the request cycle):
  - R-type, ADDI, XORI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ, BNE, J, JAL, JR: 3 cycles.
  - Each memory wait cycle adds one cycle.
- `mem_req` and `mem_we` stay stable until the cycle in which `mem_ready` is sampled high. `mem_req` drops the following cycle unless the next state also requests.
- `mem_ready` is ignored in non-request states.
- If `reset` is asserted mid-access, the request aborts immediately. Memory must tolerate a dropped request.

## Configuration
- `MC_PERF_COUNTERS_EN` defined:
  - Adds 32-bit outputs `cycle_count` and `retire_count`, both reset to 0.
  - `cycle_count` increments every cycle except in TRAP.
  - `retire_count` increments on each transition into FETCH from any state other than reset.
  - Both counters wrap at 2^32.
- Undefined: the counter ports and their logic are absent.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encoding (4-bit enum);
  - opcode and funct constants;
  - ALU command codes;
  - `pcsrc`, `alusrcb`, `regdst` and `memtoreg` encodings.
- Sub-module `mc_decode` is combinational. It maps opcode/funct to an instruction class (RTYPE, JR, LW, SW, IMM, BR, J, JAL, ILLEGAL) and to an ALU command.

## Test plan
- ADD 0x012A4020 with zero-wait memory: the FSM runs FETCH→DECODE→EXECR→RWB→FETCH; `reg_we`=1 with `regdst`=1 in cycle 4; `alu_cmd`=0 in EXECR.
- LW 0x8D280004 with `mem_ready` delayed 3 cycles in MEMRD: MEMRD lasts 4 cycles and the instruction takes 8 cycles in total; `iord`=1 throughout MEMRD.
- BEQ with `zero`=1, then BNE with `zero`=1: BEQ gives `pc_we`=1 and `pcsrc`=1 in BRANCH; BNE gives `pc_we`=0.
- JAL 0x0C000010: JAL state asserts `pc_we`, `reg_we`, `regdst`=2, `memtoreg`=2 and `pcsrc`=2 together; back in FETCH after 3 cycles.
- Opcode 0x3F: the FSM enters TRAP after DECODE and `trap`=1 stays sticky; `reset` returns it to FETCH with `trap`=0.
- `mem_ready` held low with `MEM_TIMEOUT`=4: TRAP after 4 wait cycles. Asserting `reset` in the middle of MEMWR drops `mem_we` asynchronously.
